alu_md: RTL and testbench

- Parametrised successor of the single-cycle datapath ALU. Adds an iterative multiply/divide unit with HI/LO registers.
- The combinational ALU path is unchanged in timing: result is valid in the same cycle as its operands.
- Multiply/divide runs in the background under a start/busy/done handshake. The pipeline stalls on busy when it reads HI/LO.

---
 rtl/alu_md.sv | 172 +++++++++++++++++
 tb/tb_alu_md.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_md.sv
// alu_md: single-cycle ALU plus a background radix-2 multiply/divide unit
// writing HI/LO under a start/busy/done handshake.
module alu_md #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       op,
  input  logic [SHW-1:0]   shift,
  output logic [WIDTH-1:0] result,
  output logic             alu_zero,
  input  logic             md_start,
  input  logic [2:0]       md_op,
  output logic             busy,
  output logic             md_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int HALF = WIDTH / 2;

  typedef enum logic [1:0] {sIdle = 2'd0, sRun = 2'd1, sDone = 2'd2} state_t;

  state_t               state_r;
  logic [SHW-1:0]       count_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic [WIDTH-1:0]     opnd_r;
  logic                 isDiv_r, negHi_r, negLo_r, divZero_r;
  logic                 busy_r, mdDone_r;
  logic [WIDTH-1:0]     hi_r, lo_r;

  logic                 mdSigned_s, aNeg_s, bNeg_s;
  logic [WIDTH-1:0]     aMag_s, bMag_s;
  logic [WIDTH:0]       sum_s, trial_s;
  logic [2*WIDTH-1:0]   nextAcc_s, prodFinal_s;
  logic [WIDTH-1:0]     hiFinal_s, loFinal_s;

  function automatic logic [WIDTH-1:0] negIf(input logic neg, input logic [WIDTH-1:0] v);
    negIf = neg ? ({WIDTH{1'b0}} - v) : v;
  endfunction

  // Combinational ALU result
  always_comb begin
    result = {WIDTH{1'b0}};
    case (op)
      4'b0000: result = in_a + in_b;
      4'b0001: result = in_a - in_b;
      4'b0010: result = in_a & in_b;
      4'b0011: result = in_a | in_b;
      4'b0100: result = in_a ^ in_b;
      4'b0101: result = ~(in_a | in_b);
      4'b0110: result = in_b << shift;
      4'b0111: result = in_b >> shift;
      4'b1000: result = $signed(in_b) >>> shift;
      4'b1001: result = {in_b[HALF-1:0], {HALF{1'b0}}};
      4'b1010: result = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
      4'b1011: result = {{(WIDTH-1){1'b0}}, (in_a > in_b)};
      4'b1100: result = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      4'b1101: result = {{(WIDTH-1){1'b0}}, ($signed(in_a) > $signed(in_b))};
      4'b1110: result = hi_r;
      4'b1111: result = lo_r;
      default: result = {WIDTH{1'b0}};
    endcase
  end

  assign alu_zero = (result == {WIDTH{1'b0}});

  // Even md_op codes are the signed variants; operands are reduced to magnitudes
  assign mdSigned_s = ~md_op[0];
  assign aNeg_s     = mdSigned_s & in_a[WIDTH-1];
  assign bNeg_s     = mdSigned_s & in_b[WIDTH-1];
  assign aMag_s     = negIf(aNeg_s, in_a);
  assign bMag_s     = negIf(bNeg_s, in_b);

  // One shift-add or restoring-subtract step, plus sign fix-up of the final step
  always_comb begin
    sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    trial_s = acc_r[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_r};
    if (isDiv_r) begin
      if (trial_s[WIDTH]) begin
        nextAcc_s = {acc_r[2*WIDTH-2:WIDTH-1], acc_r[WIDTH-2:0], 1'b0};
      end else begin
        nextAcc_s = {trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
      end
    end else begin
      nextAcc_s = {sum_s, acc_r[WIDTH-1:1]};
    end
    prodFinal_s = negHi_r ? ({(2*WIDTH){1'b0}} - nextAcc_s) : nextAcc_s;
    if (isDiv_r) begin
      hiFinal_s = negIf(negHi_r, nextAcc_s[2*WIDTH-1:WIDTH]);
      loFinal_s = divZero_r ? {WIDTH{1'b1}} : negIf(negLo_r, nextAcc_s[WIDTH-1:0]);
    end else begin
      hiFinal_s = prodFinal_s[2*WIDTH-1:WIDTH];
      loFinal_s = prodFinal_s[WIDTH-1:0];
    end
  end

  // Handshake state machine, iteration registers and HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= sIdle;
      count_r   <= {SHW{1'b0}};
      acc_r     <= {(2*WIDTH){1'b0}};
      opnd_r    <= {WIDTH{1'b0}};
      isDiv_r   <= 1'b0;
      negHi_r   <= 1'b0;
      negLo_r   <= 1'b0;
      divZero_r <= 1'b0;
      busy_r    <= 1'b0;
      mdDone_r  <= 1'b0;
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
    end else begin
      mdDone_r <= 1'b0;
      case (state_r)
        sIdle, sDone: begin
          if (md_start) begin
            case (md_op)
              3'b000, 3'b001, 3'b010, 3'b011: begin
                state_r   <= sRun;
                busy_r    <= 1'b1;
                count_r   <= SHW'(WIDTH - 1);
                isDiv_r   <= md_op[1];
                acc_r     <= {{WIDTH{1'b0}}, (md_op[1] ? aMag_s : bMag_s)};
                opnd_r    <= md_op[1] ? bMag_s : aMag_s;
                negHi_r   <= md_op[1] ? aNeg_s : (aNeg_s ^ bNeg_s);
                negLo_r   <= aNeg_s ^ bNeg_s;
                divZero_r <= (in_b == {WIDTH{1'b0}});
              end
              3'b100: begin
                hi_r     <= in_a;
                mdDone_r <= 1'b1;
                state_r  <= sDone;
              end
              3'b101: begin
                lo_r     <= in_a;
                mdDone_r <= 1'b1;
                state_r  <= sDone;
              end
              default: state_r <= sIdle;
            endcase
          end else begin
            state_r <= sIdle;
          end
        end
        sRun: begin
          acc_r <= nextAcc_s;
          if (count_r == {SHW{1'b0}}) begin
            hi_r     <= hiFinal_s;
            lo_r     <= loFinal_s;
            busy_r   <= 1'b0;
            mdDone_r <= 1'b1;
            state_r  <= sDone;
          end else begin
            count_r <= count_r - {{(SHW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r <= sIdle;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign md_done = mdDone_r;
  assign hi      = hi_r;
  assign lo      = lo_r;
endmodule

// File: tb/tb_alu_md.sv
// Self-checking bench for alu_md: a 32-bit and a 16-bit instance checked against
// ALU vectors and a plain-arithmetic multiply/divide reference model.
module tb_alu_md;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] a32, b32, res32, hi32, lo32;
  logic [3:0]  op32;
  logic [4:0]  sh32;
  logic [2:0]  mop32;
  logic        z32, st32, busy32, done32;

  logic [15:0] a16, b16, res16, hi16, lo16;
  logic [3:0]  op16;
  logic [3:0]  sh16;
  logic [2:0]  mop16;
  logic        z16, st16, busy16, done16;

  alu_md #(.WIDTH(32), .SHW(5)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_a(a32), .in_b(b32), .op(op32), .shift(sh32),
    .result(res32), .alu_zero(z32), .md_start(st32), .md_op(mop32),
    .busy(busy32), .md_done(done32), .hi(hi32), .lo(lo32));

  alu_md #(.WIDTH(16), .SHW(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_a(a16), .in_b(b16), .op(op16), .shift(sh16),
    .result(res16), .alu_zero(z16), .md_start(st16), .md_op(mop16),
    .busy(busy16), .md_done(done16), .hi(hi16), .lo(lo16));

  int total = 0;
  int bad = 0;
  logic [63:0] expHi [2];
  logic [63:0] expLo [2];

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
  } aluVec_t;
  aluVec_t tbl [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] aluRef(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                         input logic [4:0] s, input logic [31:0] h, input logic [31:0] l);
    logic [31:0] p2;
    p2 = 32'd1 << s;
    case (o)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~(a | b);
      4'd6:  return b * p2;
      4'd7:  return b / p2;
      4'd8:  return $signed(b) >>> s;
      4'd9:  return b * 32'd65536;
      4'd10: return (a < b) ? 32'd1 : 32'd0;
      4'd11: return (a > b) ? 32'd1 : 32'd0;
      4'd12: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd13: return ($signed(a) > $signed(b)) ? 32'd1 : 32'd0;
      4'd14: return h;
      default: return l;
    endcase
  endfunction

  function automatic void mdRef(input int w, input logic [2:0] opc, input logic [63:0] a, input logic [63:0] b,
                                input logic [63:0] oh, input logic [63:0] ol,
                                output logic [63:0] nh, output logic [63:0] nl);
    logic [63:0] mask, p;
    longint sa, sb;
    mask = (64'd1 << w) - 64'd1;
    sa = a[w-1] ? longint'(a | ~mask) : longint'(a);
    sb = b[w-1] ? longint'(b | ~mask) : longint'(b);
    nh = oh;
    nl = ol;
    case (opc)
      3'd0: begin p = 64'(sa * sb); nh = (p >> w) & mask; nl = p & mask; end
      3'd1: begin p = a * b;        nh = (p >> w) & mask; nl = p & mask; end
      3'd2, 3'd3: begin
        if (b == 64'd0) begin nl = mask; nh = a; end
        else if (opc == 3'd2) begin nl = 64'(sa / sb) & mask; nh = 64'(sa % sb) & mask; end
        else begin nl = a / b; nh = a % b; end
      end
      3'd4: nh = a;
      3'd5: nl = a;
      default: ;
    endcase
  endfunction

  task automatic sample(input int sel, output logic bz, output logic dn, output logic [63:0] h, output logic [63:0] l);
    if (sel == 0) begin bz = busy32; dn = done32; h = {32'd0, hi32}; l = {32'd0, lo32}; end
    else begin bz = busy16; dn = done16; h = {48'd0, hi16}; l = {48'd0, lo16}; end
  endtask

  // Issue one md request and check latency, hold, done pulse and HI/LO
  task automatic mdRun(input int w, input logic [2:0] opc, input logic [63:0] a, input logic [63:0] b);
    int sel, cyc;
    logic held, gBusy, gDone;
    logic [63:0] nHi, nLo, gHi, gLo;
    sel = (w == 32) ? 0 : 1;
    mdRef(w, opc, a, b, expHi[sel], expLo[sel], nHi, nLo);
    @(negedge clk);
    if (sel == 0) begin a32 = a[31:0]; b32 = b[31:0]; mop32 = opc; st32 = 1'b1; end
    else begin a16 = a[15:0]; b16 = b[15:0]; mop16 = opc; st16 = 1'b1; end
    @(posedge clk); #1;
    st32 = 1'b0; st16 = 1'b0;
    a32 = $urandom; b32 = $urandom; a16 = 16'($urandom); b16 = 16'($urandom);
    cyc = 0;
    held = 1'b1;
    sample(sel, gBusy, gDone, gHi, gLo);
    while (gBusy && cyc < 100) begin
      cyc++;
      if (gHi !== expHi[sel] || gLo !== expLo[sel]) held = 1'b0;
      @(posedge clk); #1;
      sample(sel, gBusy, gDone, gHi, gLo);
    end
    check($sformatf("w%0d op%0d busy cycles", w, opc), 64'(cyc), (opc <= 3'd3) ? 64'(w) : 64'd0);
    check($sformatf("w%0d op%0d md_done", w, opc), 64'(gDone), (opc <= 3'd5) ? 64'd1 : 64'd0);
    check($sformatf("w%0d op%0d hold", w, opc), 64'(held), 64'd1);
    check($sformatf("w%0d op%0d hi", w, opc), gHi, nHi);
    check($sformatf("w%0d op%0d lo", w, opc), gLo, nLo);
    expHi[sel] = nHi;
    expLo[sel] = nLo;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int cyc;
    logic sawDone;
    logic [31:0] e;
    rst_n = 1'b0;
    a32 = 32'd0; b32 = 32'd0; op32 = 4'd0; sh32 = 5'd0; mop32 = 3'd0; st32 = 1'b0;
    a16 = 16'd0; b16 = 16'd0; op16 = 4'd0; sh16 = 4'd0; mop16 = 3'd0; st16 = 1'b0;
    expHi[0] = 64'd0; expLo[0] = 64'd0; expHi[1] = 64'd0; expLo[1] = 64'd0;

    tbl[0]  = '{4'b0001, 32'd5,          32'd7,          5'd0,  32'hFFFF_FFFE};
    tbl[1]  = '{4'b1100, 32'hFFFF_FFFF,  32'd1,          5'd0,  32'd1};
    tbl[2]  = '{4'b1010, 32'hFFFF_FFFF,  32'd1,          5'd0,  32'd0};
    tbl[3]  = '{4'b1000, 32'd0,          32'h8000_0000,  5'd4,  32'hF800_0000};
    tbl[4]  = '{4'b0000, 32'hFFFF_FFFF,  32'd1,          5'd0,  32'd0};
    tbl[5]  = '{4'b0010, 32'hF0F0_F0F0,  32'hFF00_FF00,  5'd0,  32'hF000_F000};
    tbl[6]  = '{4'b0011, 32'hF0F0_F0F0,  32'hFF00_FF00,  5'd0,  32'hFFF0_FFF0};
    tbl[7]  = '{4'b0100, 32'hF0F0_F0F0,  32'hFF00_FF00,  5'd0,  32'h0FF0_0FF0};
    tbl[8]  = '{4'b0101, 32'hF0F0_F0F0,  32'hFF00_FF00,  5'd0,  32'h000F_000F};
    tbl[9]  = '{4'b0110, 32'd0,          32'd1,          5'd31, 32'h8000_0000};
    tbl[10] = '{4'b0111, 32'd0,          32'h8000_0000,  5'd31, 32'd1};
    tbl[11] = '{4'b1001, 32'd0,          32'h0000_ABCD,  5'd0,  32'hABCD_0000};
    tbl[12] = '{4'b1011, 32'd1,          32'hFFFF_FFFF,  5'd0,  32'd0};
    tbl[13] = '{4'b1101, 32'd1,          32'hFFFF_FFFF,  5'd0,  32'd1};
    tbl[14] = '{4'b1110, 32'd3,          32'd4,          5'd0,  32'd0};
    tbl[15] = '{4'b1111, 32'd3,          32'd4,          5'd0,  32'd0};

    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset busy", 64'(busy32), 64'd0);
    check("reset md_done", 64'(done32), 64'd0);
    check("reset hi", 64'(hi32), 64'd0);
    check("reset lo", 64'(lo32), 64'd0);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      op32 = tbl[i].op; a32 = tbl[i].a; b32 = tbl[i].b; sh32 = tbl[i].sh;
      #1;
      check($sformatf("alu tbl%0d result", i), 64'(res32), 64'(tbl[i].res));
      check($sformatf("alu tbl%0d zero", i), 64'(z32), (tbl[i].res == 32'd0) ? 64'd1 : 64'd0);
    end

    mdRun(32, 3'd1, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
    check("multu hi const", 64'(hi32), 64'hFFFF_FFFE);
    check("multu lo const", 64'(lo32), 64'h0000_0001);
    @(posedge clk); #1;
    check("md_done single pulse", 64'(done32), 64'd0);
    op32 = 4'b1111;
    #1;
    check("result reads lo", 64'(res32), 64'd1);

    mdRun(32, 3'd2, 64'hFFFF_FFF9, 64'd2);
    check("div -7/2 lo", 64'(lo32), 64'hFFFF_FFFD);
    check("div -7/2 hi", 64'(hi32), 64'hFFFF_FFFF);
    mdRun(32, 3'd2, 64'h8000_0000, 64'hFFFF_FFFF);
    check("div min/-1 lo", 64'(lo32), 64'h8000_0000);
    mdRun(32, 3'd3, 64'd9, 64'd0);
    check("divu by zero lo", 64'(lo32), 64'hFFFF_FFFF);
    check("divu by zero hi", 64'(hi32), 64'd9);

    // A second start at busy cycle 10 must be dropped entirely
    @(negedge clk); a32 = 32'd3; b32 = 32'd4; mop32 = 3'd0; st32 = 1'b1;
    @(posedge clk); #1; st32 = 1'b0;
    cyc = 0;
    while (busy32 && cyc < 100) begin
      cyc++;
      if (cyc == 10) begin @(negedge clk); st32 = 1'b1; a32 = 32'd100; end
      @(posedge clk); #1; st32 = 1'b0;
    end
    check("ignored start busy cycles", 64'(cyc), 64'd32);
    check("ignored start md_done", 64'(done32), 64'd1);
    check("ignored start hi", 64'(hi32), 64'd0);
    check("ignored start lo", 64'(lo32), 64'd12);
    expHi[0] = 64'd0; expLo[0] = 64'd12;
    mdRun(32, 3'd4, 64'h1234, 64'd0);
    mdRun(32, 3'd5, 64'hCAFE_F00D, 64'd0);
    mdRun(32, 3'd6, 64'h5555, 64'h7777);

    for (int i = 0; i < 30; i++) mdRun(32, 3'($urandom_range(0, 7)), 64'(pick()), 64'(pick()));
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      op32 = 4'($urandom); a32 = pick(); b32 = pick(); sh32 = 5'($urandom);
      #1;
      e = aluRef(op32, a32, b32, sh32, expHi[0][31:0], expLo[0][31:0]);
      check($sformatf("alu rnd%0d op%0d", i, op32), 64'(res32), 64'(e));
      check($sformatf("alu rnd%0d zero", i), 64'(z32), (e == 32'd0) ? 64'd1 : 64'd0);
    end

    // Reset in the middle of a divide aborts it without a done pulse
    @(negedge clk); a32 = 32'd1000; b32 = 32'd7; mop32 = 3'd2; st32 = 1'b1;
    @(posedge clk); #1; st32 = 1'b0;
    repeat (14) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort busy", 64'(busy32), 64'd0);
    check("abort md_done", 64'(done32), 64'd0);
    check("abort hi", 64'(hi32), 64'd0);
    check("abort lo", 64'(lo32), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    expHi[0] = 64'd0; expLo[0] = 64'd0; expHi[1] = 64'd0; expLo[1] = 64'd0;
    sawDone = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done32 || busy32) sawDone = 1'b1;
    end
    check("no activity after abort", 64'(sawDone), 64'd0);
    mdRun(32, 3'd0, 64'd6, 64'd7);
    check("mult 6*7 lo", 64'(lo32), 64'd42);

    mdRun(16, 3'd0, 64'h8000, 64'd2);
    check("w16 mult hi const", 64'(hi16), 64'hFFFF);
    check("w16 mult lo const", 64'(lo16), 64'h0000);
    @(negedge clk); op16 = 4'b1001; b16 = 16'h00AB;
    #1;
    check("w16 half shift", 64'(res16), 64'hAB00);
    check("w16 half shift zero", 64'(z16), 64'd0);
    op16 = 4'b1110;
    #1;
    check("w16 result reads hi", 64'(res16), 64'hFFFF);
    mdRun(16, 3'd2, 64'h8000, 64'hFFFF);
    mdRun(16, 3'd3, 64'h1234, 64'd0);
    for (int i = 0; i < 6; i++) mdRun(16, 3'($urandom_range(0, 5)), 64'(16'($urandom)), 64'(16'($urandom)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
